load_store_unit: RTL and testbench

Byte-serial memory initiator between the RV32I datapath and the byte-wide data-memory port. Accepts one load or store request at a time (RV32I funct3 encoding), sequences it as 1, 2 or 4 little-endian byte accesses, and returns the sign- or zero-extended load result or a store completion. This converts the core's data-memory access into a multi-cycle, handshaked transaction.

---
 rtl/load_store_unit_pkg.sv | 41 ++++
 rtl/load_store_unit_if.sv | 36 +++
 rtl/load_store_unit_load_extend.sv | 22 ++
 rtl/load_store_unit.sv | 117 +++++++++++
 tb/tb_load_store_unit.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the byte-serial load/store unit:
// funct3 encodings, FSM states and request decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } lsu_state_t;

    function automatic logic [2:0] bytes_for(input logic [2:0] f3);
        logic [2:0] n;
        n = 3'd0;
        unique case (f3)
            F3_B, F3_BU: n = 3'd1;
            F3_H, F3_HU: n = 3'd2;
            F3_W:        n = 3'd4;
            default:     n = 3'd0;
        endcase
        return n;
    endfunction

    // Unsigned variants only make sense for loads.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        unique case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response handshake plus the byte-wide
// data-memory port of the load/store unit.
interface load_store_unit_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [2:0]               req_funct3;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [DATA_WIDTH-1:0]    resp_rdata;
    logic                     resp_err;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [7:0]               mem_wdata;
    logic                     mem_we;
    logic [7:0]               mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// Sign/zero extension of gathered load bytes; shared with the
// datapath writeback mux.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdbuf,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_rdbuf;
        unique case (i_funct3)
            F3_B:    o_data = {{24{i_rdbuf[7]}}, i_rdbuf[7:0]};
            F3_H:    o_data = {{16{i_rdbuf[15]}}, i_rdbuf[15:0]};
            F3_BU:   o_data = {24'd0, i_rdbuf[7:0]};
            F3_HU:   o_data = {16'd0, i_rdbuf[15:0]};
            default: o_data = i_rdbuf;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store initiator: one request at a time, split
// into 1/2/4 little-endian byte accesses on the memory port.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic clk,
    input  logic rst_n,
    load_store_unit_if.slave bus
);

    lsu_state_t               r_state;
    lsu_state_t               w_next;
    logic                     r_we;
    logic [2:0]               r_f3;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [1:0]               r_idx;
    logic [1:0]               r_last;
    logic                     r_err;
    logic [31:0]              r_rdbuf;

    logic                     w_accept;
    logic                     w_legal;
    logic [2:0]               w_nbytes;
    logic [4:0]               w_bit;
    logic [31:0]              w_ext;

    assign w_legal  = f3_legal(bus.req_we, bus.req_funct3);
    assign w_nbytes = bytes_for(bus.req_funct3);
    assign w_accept = (r_state == S_IDLE) && bus.req_valid;
    assign w_bit    = {r_idx, 3'b000};

    load_extend u_ext (
        .i_rdbuf  (r_rdbuf),
        .i_funct3 (r_f3),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_rdata  = '0;
        bus.resp_err    = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        unique case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_next = w_legal ? S_ACCESS : S_RESP;
                end
            end
            S_ACCESS: begin
                bus.mem_addr = r_addr + ADDRESS_WIDTH'(r_idx);
                bus.mem_we   = r_we;
                if (r_we) begin
                    bus.mem_wdata = r_wdata[w_bit +: 8];
                end
                if (r_idx == r_last) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = r_err;
                if (!r_we && !r_err) begin
                    bus.resp_rdata = DATA_WIDTH'(w_ext);
                end
                if (bus.resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_f3    <= 3'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_idx   <= 2'd0;
            r_last  <= 2'd0;
            r_err   <= 1'b0;
            r_rdbuf <= '0;
        end else if (w_accept) begin
            r_we    <= bus.req_we;
            r_f3    <= bus.req_funct3;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_idx   <= 2'd0;
            r_last  <= 2'(w_nbytes - 3'd1);
            r_err   <= !w_legal;
            r_rdbuf <= '0;
        end else if (r_state == S_ACCESS) begin
            r_idx <= r_idx + 2'd1;
            if (!r_we) begin
                r_rdbuf[w_bit +: 8] <= bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-abort
// sequence and random requests against a byte-array memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       pl_en = 1'b0;
    logic [7:0] pl_a = 8'd0;
    logic [7:0] pl_d = 8'd0;

    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t wr_q[$];

    always @(negedge clk) begin
        if (bus.mem_we) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1;
        pl_a = a;
        pl_d = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Reference: legality, byte count and extended value from plain arithmetic.
    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr,
                                  output logic [31:0] rd,
                                  output logic err, output int n);
        longint v;
        err = !((f3 inside {3'b000, 3'b001, 3'b010}) ||
                (!we && (f3 inside {3'b100, 3'b101})));
        n = err ? 0 : (f3[1:0] == 2'b00 ? 1 : (f3[1:0] == 2'b01 ? 2 : 4));
        rd = 32'd0;
        v = 0;
        if (!err && !we) begin
            for (int i = 0; i < n; i++)
                v += longint'(ref_mem[8'(addr + 32'(i))]) << (8 * i);
            if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
                v -= longint'(1) << (8 * n);
            rd = v[31:0];
        end
    endfunction

    task automatic run_req(input string nm, input logic we,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int stall,
                           input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] mrd;
        logic [31:0] rd0;
        logic        merr;
        logic        er0;
        logic        stable;
        int          n;
        int          lat;
        model(we, f3, addr, mrd, merr, n);
        wr_q.delete();
        @(negedge clk);
        chk({nm, " req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_funct3 = f3;
        bus.req_addr = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we = 1'($urandom_range(0, 1));
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_addr = $urandom;
        bus.req_wdata = $urandom;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(n + 1));
        chk({nm, " rdata"}, bus.resp_rdata, exp_rd);
        chk({nm, " err"}, 32'(bus.resp_err), 32'(exp_err));
        rd0 = bus.resp_rdata;
        er0 = bus.resp_err;
        stable = 1'b1;
        bus.req_valid = 1'b1;
        repeat (stall) begin
            @(posedge clk);
            #1;
            if (!bus.resp_valid || bus.req_ready ||
                bus.resp_rdata !== rd0 || bus.resp_err !== er0)
                stable = 1'b0;
        end
        if (stall > 0) chk({nm, " stall hold"}, 32'(stable), 32'd1);
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b0;
        chk({nm, " post-hs"}, {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
        if (we && !merr) begin
            chk({nm, " nwrites"}, 32'(wr_q.size()), 32'(n));
            for (int i = 0; i < n && i < wr_q.size(); i++) begin
                chk({nm, " wr addr"}, wr_q[i].a, addr + 32'(i));
                chk({nm, " wr data"}, 32'(wr_q[i].d), 32'(wdata[8*i +: 8]));
                ref_mem[8'(addr + 32'(i))] = wdata[8*i +: 8];
            end
        end else begin
            chk({nm, " nwrites"}, 32'(wr_q.size()), 32'd0);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stall;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt[16];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] mrd;
        logic        merr;
        int          n;
        logic        rwe;
        logic [2:0]  rf3;
        logic [31:0] raddr;
        logic [31:0] rwd;

        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0;
        bus.resp_ready = 1'b0;

        vt[0]  = '{1'b0, F3_W,   32'h0001_0000, 32'h0, 0, 32'h4433_2211, 1'b0};
        vt[1]  = '{1'b0, F3_B,   32'h0001_0005, 32'h0, 0, 32'hFFFF_FF80, 1'b0};
        vt[2]  = '{1'b0, F3_BU,  32'h0001_0005, 32'h0, 1, 32'h0000_0080, 1'b0};
        vt[3]  = '{1'b1, F3_H,   32'h0001_0003, 32'hDEAD_BEEF, 0, 32'h0, 1'b0};
        vt[4]  = '{1'b0, F3_HU,  32'h0001_0003, 32'h0, 0, 32'h0000_BEEF, 1'b0};
        vt[5]  = '{1'b0, F3_H,   32'h0001_0003, 32'h0, 0, 32'hFFFF_BEEF, 1'b0};
        vt[6]  = '{1'b0, 3'b011, 32'h0001_0000, 32'h0, 0, 32'h0, 1'b1};
        vt[7]  = '{1'b1, F3_BU,  32'h0001_0000, 32'hFFFF_FFFF, 2, 32'h0, 1'b1};
        vt[8]  = '{1'b0, F3_W,   32'h0001_0000, 32'h0, 5, 32'hEF33_2211, 1'b0};
        vt[9]  = '{1'b0, F3_W,   32'hFFFF_FFFE, 32'h0, 0, 32'h2211_B2A1, 1'b0};
        vt[10] = '{1'b1, F3_W,   32'hFFFF_FFFF, 32'h0102_0304, 0, 32'h0, 1'b0};
        vt[11] = '{1'b0, F3_W,   32'hFFFF_FFFF, 32'h0, 0, 32'h0102_0304, 1'b0};
        vt[12] = '{1'b0, 3'b111, 32'h0001_0004, 32'h0, 0, 32'h0, 1'b1};
        vt[13] = '{1'b1, F3_HU,  32'h0001_0004, 32'h1234_5678, 0, 32'h0, 1'b1};
        vt[14] = '{1'b1, F3_B,   32'h0001_0006, 32'h1234_56AA, 0, 32'h0, 1'b0};
        vt[15] = '{1'b0, F3_B,   32'h0001_0006, 32'h0, 0, 32'hFFFF_FFAA, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst mem_addr", bus.mem_addr, 32'd0);
        chk("rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
        preload(8'h00, 8'h11);
        preload(8'h01, 8'h22);
        preload(8'h02, 8'h33);
        preload(8'h03, 8'h44);
        preload(8'h05, 8'h80);
        preload(8'hFE, 8'hA1);
        preload(8'hFF, 8'hB2);

        for (int i = 0; i < 16; i++)
            run_req($sformatf("vec%0d", i), vt[i].we, vt[i].f3, vt[i].addr,
                    vt[i].wdata, vt[i].stall, vt[i].exp_rd, vt[i].exp_err);

        // Reset while the third byte of a word store is on the bus.
        for (int i = 16; i < 20; i++) preload(8'(i), 8'h55);
        wr_q.delete();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_addr = 32'h0001_0010;
        bus.req_wdata = 32'hA1B2_C3D4;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort pre we", 32'(bus.mem_we), 32'd1);
        chk("abort pre addr", bus.mem_addr, 32'h0001_0012);
        rst_n = 1'b0;
        #1;
        chk("abort mem_we", 32'(bus.mem_we), 32'd0);
        chk("abort mem_addr", bus.mem_addr, 32'd0);
        chk("abort mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("abort req_ready", 32'(bus.req_ready), 32'd1);
        chk("abort resp_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort nwrites", 32'(wr_q.size()), 32'd2);
        ref_mem[8'h10] = 8'hD4;
        ref_mem[8'h11] = 8'hC3;
        run_req("abort LW", 1'b0, F3_W, 32'h0001_0010, 32'h0, 0,
                32'h5555_C3D4, 1'b0);

        for (int k = 0; k < 150; k++) begin
            rwe = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            raddr = $urandom;
            rwd = $urandom;
            model(rwe, rf3, raddr, mrd, merr, n);
            run_req($sformatf("rnd%0d", k), rwe, rf3, raddr, rwd,
                    $urandom_range(0, 2), mrd, merr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
